// File: rtl/seq_mac_accumulator.sv
// Iterative shift-and-add multiply-accumulate stage: one operand pair per WIDTH+2 cycles,
// product added into a wrapping accumulator with a sticky carry-out flag.
module seq_mac_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    mc;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mb;
  logic [CNT_W-1:0] cnt;
  logic             clr_q;
  logic             last_iter;
  logic [ACC_W:0]   sum;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Extra top bit of sum captures the carry out of the accumulator.
  assign sum = (clr_q ? '0 : {1'b0, acc}) + (ACC_W + 1)'(prod);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        if (last_iter) state_nxt = ACC;
      end
      ACC: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: every register is cleared; an in-flight product is simply discarded.
      state     <= IDLE;
      mc        <= '0;
      prod      <= '0;
      mb        <= '0;
      cnt       <= '0;
      clr_q     <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mc    <= {{WIDTH{1'b0}}, a};
            mb    <= b;
            prod  <= '0;
            cnt   <= '0;
            clr_q <= acc_clr;
          end
        end
        MUL: begin
          if (mb[0]) prod <= prod + mc;
          mc  <= mc << 1;
          mb  <= mb >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        ACC: begin
          acc       <= sum[ACC_W-1:0];
          ovf       <= (clr_q ? 1'b0 : ovf) | sum[ACC_W];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_accumulator.sv
// Scoreboard bench for seq_mac_accumulator: expected acc/ovf and due cycle are queued
// at acceptance and compared when out_valid pulses.
module tb_seq_mac_accumulator;

  localparam int WIDTH = 4;
  localparam int ACC_W = 12;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             acc_clr;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             busy;

  exp_t             sb[$];
  logic [ACC_W-1:0] model_acc = '0;
  logic             model_ovf = 1'b0;
  int               cyc       = 0;
  int               errors    = 0;
  int               checks    = 0;

  seq_mac_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .acc       (acc),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Every out_valid pulse must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d acc=%0d ovf=%0b", cyc, acc, ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (acc !== e.acc || ovf !== e.ovf || cyc !== e.due)
        begin
          errors++;
          $display("FAIL result got acc=%0d ovf=%0b cyc=%0d expected acc=%0d ovf=%0b cyc=%0d",
                   acc, ovf, cyc, e.acc, e.ovf, e.due);
        end
      end
    end
  end

  // Waits for in_ready, presents one pair for exactly one accepting edge; returns #1 after it.
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic clr, input bit push);
    int                 n = 0;
    logic [ACC_W:0]     s;
    logic [2*WIDTH-1:0] p;
    exp_t               e;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b expected 1", in_ready);
    end
    op_a     = ta;
    op_b     = tb_v;
    acc_clr  = clr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      p         = ta * tb_v;
      s         = (clr ? '0 : {1'b0, model_acc}) + (ACC_W + 1)'(p);
      model_ovf = (clr ? 1'b0 : model_ovf) | s[ACC_W];
      model_acc = s[ACC_W-1:0];
      e.acc     = model_acc;
      e.ovf     = model_ovf;
      e.due     = cyc + WIDTH + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    in_valid = 1'b1;
    op_a     = 4'd5;
    op_b     = 4'd5;
    acc_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++;
    if (acc !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_acc got acc=%0d ovf=%0b expected acc=0 ovf=0", acc, ovf);
    end
  endtask

  task automatic test_basic();
    accept(4'd3, 4'd2, 1'b1, 1'b1);
    wait_done();
    checks++;
    if (acc !== 12'd6 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_first got acc=%0d ovf=%0b expected acc=6 ovf=0", acc, ovf);
    end
    accept(4'd15, 4'd15, 1'b0, 1'b1);
    // Handshake must stay closed for the five cycles between accept and result.
    for (int i = 0; i < WIDTH + 1; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy cycle=%0d got in_ready=%0b busy=%0b expected 0/1", i, in_ready, busy);
      end
    end
    wait_done();
    checks++;
    if (acc !== 12'd231) begin errors++; $display("FAIL basic_second got acc=%0d expected 231", acc); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 19; i++) begin
      accept(4'd15, 4'd15, (i == 0), 1'b1);
      wait_done();
      if (i == 17) begin
        checks++;
        if (acc !== 12'd4050 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL wrap_18 got acc=%0d ovf=%0b expected acc=4050 ovf=0", acc, ovf);
        end
      end
    end
    checks++;
    if (acc !== 12'd179 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_19 got acc=%0d ovf=%0b expected acc=179 ovf=1", acc, ovf);
    end
    accept(4'd1, 4'd1, 1'b1, 1'b1);
    wait_done();
    checks++;
    if (acc !== 12'd1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear got acc=%0d ovf=%0b expected acc=1 ovf=0", acc, ovf);
    end
  endtask

  task automatic test_ignore_busy();
    accept(4'd5, 4'd6, 1'b1, 1'b1);
    @(posedge clk); #1;
    op_a     = 4'd7;
    op_b     = 4'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (acc !== 12'd30) begin errors++; $display("FAIL ignore_busy got acc=%0d expected 30", acc); end
  endtask

  task automatic test_reset_mid();
    accept(4'd9, 4'd9, 1'b0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn    = 1'b1;
    model_acc = '0;
    model_ovf = 1'b0;
    checks++;
    if (acc !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got acc=%0d ovf=%0b in_ready=%0b expected 0/0/1", acc, ovf, in_ready);
    end
    repeat (10) @(posedge clk);
    #1;
    accept(4'd2, 4'd5, 1'b0, 1'b1);
    wait_done();
    checks++;
    if (acc !== 12'd10) begin errors++; $display("FAIL reset_mid_next got acc=%0d expected 10", acc); end
  endtask

  task automatic test_zero();
    accept(4'd0, 4'd13, 1'b0, 1'b1);
    wait_done();
    checks++;
    if (acc !== 12'd10) begin errors++; $display("FAIL zero_hold got acc=%0d expected 10", acc); end
    accept(4'd15, 4'd15, 1'b0, 1'b1);
    wait_done();
    accept(4'd0, 4'd7, 1'b1, 1'b1);
    wait_done();
    checks++;
    if (acc !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear got acc=%0d ovf=%0b expected 0/0", acc, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_busy();
    test_reset_mid();
    test_zero();
    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
